debug_uart_rx: RTL and testbench

- Receive-side counterpart to the debug UART transmitter: 8N1 asynchronous serial receiver, LSB first, fixed bit rate derived from the system clock.
- Synchronises the raw RX pin, validates the start bit, samples each bit at its midpoint and holds one received byte for the CPU.
- Sits beside the debug TX in the top level. Its data, status and read strobe are mapped onto a debug peripheral address for CPU polling.

---
 rtl/debug_uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_debug_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_rx.sv
// 8N1 debug UART receiver: two-flop input synchroniser, mid-bit sampling,
// single-byte holding register with sticky framing and overrun flags.
module debug_uart_rx #(
    parameter int CLK_HZ   = 64_000_000,
    parameter int BIT_RATE = 4_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    input  logic       uart_rx_read,
    input  logic       uart_rx_err_clr,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       uart_rx_busy,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_overrun
);
    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_bad_rate
            $error("debug_uart_rx: CLK_HZ/BIT_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic [7:0]       r_data;
    logic [7:0]       w_data_next;
    logic             r_valid;
    logic             w_valid_next;
    logic             r_frame_err;
    logic             w_frame_err_next;
    logic             r_overrun;
    logic             w_overrun_next;
    logic             w_rxd_s;
    logic             w_cnt_zero;
    logic             w_byte_done;
    logic             w_ferr_set;

    assign w_rxd_s    = r_sync2;
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= uart_rxd;
            r_sync2     <= r_sync1;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_overrun   <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_byte_done    = 1'b0;
        w_ferr_set     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxd_s) begin
                    w_state_next = S_START;
                    w_cnt_next   = HALF_LOAD;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    if (w_rxd_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = '0;
                        w_cnt_next     = FULL_LOAD;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    // LSB arrives first, so shifting right leaves bit 0 in [0]
                    w_shift_next = {w_rxd_s, r_shift[7:1]};
                    w_cnt_next   = FULL_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    if (w_rxd_s) begin
                        w_byte_done  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr_set   = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (w_rxd_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A completed byte takes priority over a coincident read, and flag sets
    // take priority over a coincident clear.
    always_comb begin
        w_data_next      = w_byte_done ? r_shift : r_data;
        w_valid_next     = r_valid;
        w_overrun_next   = r_overrun;
        w_frame_err_next = r_frame_err;
        if (w_byte_done) begin
            w_valid_next = 1'b1;
        end else if (uart_rx_read) begin
            w_valid_next = 1'b0;
        end
        if (w_byte_done && r_valid && !uart_rx_read) begin
            w_overrun_next = 1'b1;
        end else if (uart_rx_err_clr) begin
            w_overrun_next = 1'b0;
        end
        if (w_ferr_set) begin
            w_frame_err_next = 1'b1;
        end else if (uart_rx_err_clr) begin
            w_frame_err_next = 1'b0;
        end
    end

    assign uart_rx_data      = r_data;
    assign uart_rx_valid     = r_valid;
    assign uart_rx_busy      = (r_state != S_IDLE);
    assign uart_rx_frame_err = r_frame_err;
    assign uart_rx_overrun   = r_overrun;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed bench for debug_uart_rx at the default 16 clocks per bit.
module tb_debug_uart_rx;
    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       uart_rxd;
    logic       uart_rx_read;
    logic       uart_rx_err_clr;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_busy;
    logic       uart_rx_frame_err;
    logic       uart_rx_overrun;

    int n_checks;
    int n_fail;

    // Snapshots taken while a frame is driven; c counts edges from the start edge.
    logic       s_valid153;
    logic       s_valid154;
    logic       s_valid155;
    logic [7:0] s_data154;
    logic       s_ovr154;
    logic       s_ferr154;
    logic       s_busy154;
    logic       s_busy5;
    logic       s_busy10;
    int         s_busy_gap;

    debug_uart_rx dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .uart_rxd         (uart_rxd),
        .uart_rx_read     (uart_rx_read),
        .uart_rx_err_clr  (uart_rx_err_clr),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_busy     (uart_rx_busy),
        .uart_rx_frame_err(uart_rx_frame_err),
        .uart_rx_overrun  (uart_rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         read_c;
        logic       pre_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame (start, 8 data LSB first, stop, then tail level).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic tail,
                              input int read_c, input int last_c);
        int   k;
        logic b;
        s_busy_gap = 0;
        for (int c = 0; c <= last_c; c++) begin
            k = c / CPB;
            if (k == 0)      b = 1'b0;
            else if (k <= 8) b = d[k-1];
            else if (k == 9) b = stop_bit;
            else             b = tail;
            uart_rxd     = b;
            uart_rx_read = (c == read_c);
            @(posedge clk);
            #1;
            if (c >= 2 && c <= 153 && !uart_rx_busy) s_busy_gap++;
            if (c == 5)   s_busy5 = uart_rx_busy;
            if (c == 10)  s_busy10 = uart_rx_busy;
            if (c == 153) s_valid153 = uart_rx_valid;
            if (c == 154) begin
                s_valid154 = uart_rx_valid;
                s_data154  = uart_rx_data;
                s_ovr154   = uart_rx_overrun;
                s_ferr154  = uart_rx_frame_err;
                s_busy154  = uart_rx_busy;
            end
            if (c == 155) s_valid155 = uart_rx_valid;
        end
        uart_rx_read = 1'b0;
    endtask

    task automatic pulse_clr();
        uart_rx_err_clr = 1'b1;
        tick(1);
        uart_rx_err_clr = 1'b0;
    endtask

    task automatic pulse_read();
        uart_rx_read = 1'b1;
        tick(1);
        uart_rx_read = 1'b0;
    endtask

    initial begin
        int valid_hits;
        int busy_low;
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        uart_rxd        = 1'b1;
        uart_rx_read    = 1'b0;
        uart_rx_err_clr = 1'b0;

        vecs[0] = '{d: 8'hA5, read_c: 155, pre_valid: 1'b0, exp_ovr: 1'b0};
        vecs[1] = '{d: 8'h00, read_c: 155, pre_valid: 1'b0, exp_ovr: 1'b0};
        vecs[2] = '{d: 8'hFF, read_c: 155, pre_valid: 1'b0, exp_ovr: 1'b0};
        vecs[3] = '{d: 8'h3C, read_c: 155, pre_valid: 1'b0, exp_ovr: 1'b0};
        vecs[4] = '{d: 8'h11, read_c: -1,  pre_valid: 1'b0, exp_ovr: 1'b0};
        vecs[5] = '{d: 8'h22, read_c: -1,  pre_valid: 1'b1, exp_ovr: 1'b1};

        tick(3);
        chk("reset_data", {24'h0, uart_rx_data}, 32'h0);
        chk("reset_valid", {31'h0, uart_rx_valid}, 32'h0);
        chk("reset_busy", {31'h0, uart_rx_busy}, 32'h0);
        chk("reset_ferr", {31'h0, uart_rx_frame_err}, 32'h0);
        chk("reset_ovr", {31'h0, uart_rx_overrun}, 32'h0);
        rst_n = 1'b1;
        tick(4);

        // Back-to-back frames, then two unread bytes to provoke overrun.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].d, 1'b1, 1'b1, vecs[i].read_c, 159);
            $display("frame %0d: sent 0x%02h, received 0x%02h valid=%0b ovr=%0b",
                     i, vecs[i].d, s_data154, s_valid154, s_ovr154);
            chk("pre_valid", {31'h0, s_valid153}, {31'h0, vecs[i].pre_valid});
            chk("valid_rise", {31'h0, s_valid154}, 32'h1);
            chk("data", {24'h0, s_data154}, {24'h0, vecs[i].d});
            chk("overrun", {31'h0, s_ovr154}, {31'h0, vecs[i].exp_ovr});
            chk("ferr_clean", {31'h0, s_ferr154}, 32'h0);
            chk("busy_in_frame", s_busy_gap, 32'd0);
            chk("busy_after_stop", {31'h0, s_busy154}, 32'h0);
            if (vecs[i].read_c == 155)
                chk("read_clears", {31'h0, s_valid155}, 32'h0);
        end

        pulse_clr();
        $display("err_clr: ovr=%0b valid=%0b", uart_rx_overrun, uart_rx_valid);
        chk("ovr_cleared", {31'h0, uart_rx_overrun}, 32'h0);
        chk("valid_kept", {31'h0, uart_rx_valid}, 32'h1);

        // Read lands on the completion edge of 0x33: no overrun.
        send_frame(8'h33, 1'b1, 1'b1, 154, 159);
        $display("collision: data=0x%02h valid=%0b ovr=%0b", s_data154, s_valid154, s_ovr154);
        chk("coll_pre_valid", {31'h0, s_valid153}, 32'h1);
        chk("coll_data", {24'h0, s_data154}, 32'h33);
        chk("coll_valid", {31'h0, s_valid154}, 32'h1);
        chk("coll_ovr", {31'h0, s_ovr154}, 32'h0);
        pulse_read();
        chk("read_valid0", {31'h0, uart_rx_valid}, 32'h0);

        // Three-cycle low glitch must be rejected at the start sample.
        for (int c = 0; c < 20; c++) begin
            uart_rxd = (c < 3) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (c == 5)  s_busy5 = uart_rx_busy;
            if (c == 10) s_busy10 = uart_rx_busy;
        end
        $display("glitch: busy@5=%0b busy@10=%0b valid=%0b", s_busy5, s_busy10, uart_rx_valid);
        chk("glitch_busy_start", {31'h0, s_busy5}, 32'h1);
        chk("glitch_busy_end", {31'h0, s_busy10}, 32'h0);
        chk("glitch_valid", {31'h0, uart_rx_valid}, 32'h0);
        chk("glitch_ferr", {31'h0, uart_rx_frame_err}, 32'h0);

        // Bad stop bit followed by a long break.
        send_frame(8'h55, 1'b0, 1'b0, -1, 159);
        $display("framing: ferr=%0b valid=%0b busy=%0b", s_ferr154, s_valid154, s_busy154);
        chk("frame_err_set", {31'h0, s_ferr154}, 32'h1);
        chk("frame_valid", {31'h0, s_valid154}, 32'h0);
        chk("frame_wait_busy", {31'h0, s_busy154}, 32'h1);
        valid_hits = 0;
        busy_low   = 0;
        uart_rxd   = 1'b0;
        for (int c = 0; c < 40 * CPB; c++) begin
            tick(1);
            if (uart_rx_valid) valid_hits++;
            if (!uart_rx_busy) busy_low++;
        end
        $display("break: valid_hits=%0d busy_low=%0d", valid_hits, busy_low);
        chk("break_no_byte", valid_hits, 32'd0);
        chk("break_held_busy", busy_low, 32'd0);
        uart_rxd = 1'b1;
        tick(5);
        chk("break_release_idle", {31'h0, uart_rx_busy}, 32'h0);

        send_frame(8'h81, 1'b1, 1'b1, -1, 159);
        $display("after break: data=0x%02h valid=%0b ferr=%0b", s_data154, s_valid154, s_ferr154);
        chk("rx81_data", {24'h0, s_data154}, 32'h81);
        chk("rx81_valid", {31'h0, s_valid154}, 32'h1);
        chk("ferr_sticky", {31'h0, s_ferr154}, 32'h1);
        pulse_clr();
        chk("ferr_cleared", {31'h0, uart_rx_frame_err}, 32'h0);

        // Asynchronous reset between data bits 3 and 4 of 0xC3.
        send_frame(8'hC3, 1'b1, 1'b1, -1, 85);
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        #1;
        $display("async reset: data=0x%02h valid=%0b busy=%0b", uart_rx_data, uart_rx_valid, uart_rx_busy);
        chk("arst_data", {24'h0, uart_rx_data}, 32'h0);
        chk("arst_valid", {31'h0, uart_rx_valid}, 32'h0);
        chk("arst_busy", {31'h0, uart_rx_busy}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        chk("arst_no_partial", {31'h0, uart_rx_valid}, 32'h0);

        send_frame(8'h7E, 1'b1, 1'b1, -1, 159);
        $display("post reset: data=0x%02h valid=%0b ferr=%0b ovr=%0b",
                 s_data154, s_valid154, s_ferr154, s_ovr154);
        chk("rx7e_data", {24'h0, s_data154}, 32'h7E);
        chk("rx7e_valid", {31'h0, s_valid154}, 32'h1);
        chk("rx7e_ferr", {31'h0, s_ferr154}, 32'h0);
        chk("rx7e_ovr", {31'h0, s_ovr154}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
